// File: rtl/act_stream_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : act_stream_dispatcher
// Brief    : Streams num_tiles activation tiles from the activation buffer
//            (addresses base_addr + i*addr_stride) to the PE array through a
//            credit-checked output FIFO. It sustains one tile per cycle.
//            Optional macro ACT_DISP_PERF_EN adds the stall_cycles and
//            starve_cycles performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module act_stream_dispatcher #(
  parameter int ADDR_WIDTH = 8,
  parameter int ACT_WIDTH  = 1024,
  parameter int CNT_WIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] addr_stride,
  input  logic [CNT_WIDTH-1:0]  num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [ACT_WIDTH-1:0]  buf_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACT_WIDTH-1:0]  out_acts
`ifdef ACT_DISP_PERF_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           starve_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  popped_q, popped_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      fcnt_q, fcnt_d;
  logic [ACT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [ACT_WIDTH-1:0]  mem_d [FIFO_DEPTH];

  logic start_idle;
  logic accept;
  logic zero_job;
  logic issue;
  logic push;
  logic pop;
  logic last_pop;

  // Decode of job acceptance, read issue and FIFO handshakes.
  // The read strobe is registered, so the issue decision is made one cycle
  // ahead. occ_q counts issued-but-not-popped tiles, which is the
  // fifo_count + inflight credit.
  always_comb begin
    start_idle = start && (state_q == ST_IDLE);
    accept     = start_idle && (num_tiles != '0);
    zero_job   = start_idle && (num_tiles == '0);
    issue      = accept ||
                 ((state_q == ST_RUN) && (issued_q < count_q) && (occ_q < DEPTH_C));
    push       = vld_q[RD_LATENCY-1];
    pop        = out_valid && out_ready;
    last_pop   = (state_q == ST_RUN) && pop && (popped_q == count_q - CNT_WIDTH'(1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (last_pop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the next values of the registered control outputs
  always_comb begin
    busy_d    = (state_d == ST_RUN);
    done_d    = last_pop || zero_job;
    rd_en_d   = issue;
    rd_addr_d = rd_addr_q;
    if (accept)     rd_addr_d = base_addr;
    else if (issue) rd_addr_d = next_addr_q;
  end

  // Job parameter latching, address generation and the tile counters
  always_comb begin
    stride_d    = stride_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    if (accept) begin
      stride_d    = addr_stride;
      count_d     = num_tiles;
      next_addr_d = base_addr + addr_stride;
      issued_d    = CNT_WIDTH'(1);
      popped_d    = '0;
    end else begin
      if (issue) begin
        next_addr_d = next_addr_q + stride_q;
        issued_d    = issued_q + CNT_WIDTH'(1);
      end
      if (pop) popped_d = popped_q + CNT_WIDTH'(1);
    end
    occ_d = occ_q + OCC_W'(issue) - OCC_W'(pop);
  end

  // In-flight read tracking: rd_en enters the shift register, and the bit
  // leaving the top marks the cycle when buf_rd_data is valid.
  generate
    if (RD_LATENCY == 1) begin : g_vld_lat1
      always_comb vld_d = rd_en_q;
    end else begin : g_vld_latn
      always_comb vld_d = {vld_q[RD_LATENCY-2:0], rd_en_q};
    end
  endgenerate

  // Output FIFO pointer, occupancy and storage update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    fcnt_d   = fcnt_q + OCC_W'(push) - OCC_W'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q] = buf_rd_data;
  end

  // Control and datapath registers; reset drops in-flight reads and FIFO contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      next_addr_q <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      occ_q       <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      next_addr_q <= next_addr_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      occ_q       <= occ_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // FIFO storage; validity is tracked by fcnt_q, so no reset is needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

`ifndef SYNTHESIS
  // The credit rule must keep a push from ever landing on a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && (fcnt_q == DEPTH_C)));
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign buf_rd_en   = rd_en_q;
  assign buf_rd_addr = rd_addr_q;
  assign out_valid   = (fcnt_q != '0);
  assign out_acts    = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef ACT_DISP_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] starve_q, starve_d;

  // Saturating stall/starve counters, cleared when a job is accepted
  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (start_idle) begin
      stall_d  = '0;
      starve_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != 16'hFFFF))
        stall_d = stall_q + 16'd1;
      if (busy_q && !out_valid && out_ready && (starve_q != 16'hFFFF))
        starve_d = starve_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_stream_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_stream_dispatcher
// Brief    : Directed self-checking bench for act_stream_dispatcher
//            (RD_LATENCY=1, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_stream_dispatcher;
  localparam int ADDR_WIDTH = 8;
  localparam int ACT_WIDTH  = 1024;
  localparam int CNT_WIDTH  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] base_addr = '0;
  logic [ADDR_WIDTH-1:0] addr_stride = '0;
  logic [CNT_WIDTH-1:0]  num_tiles = '0;
  logic                  busy, done, buf_rd_en, out_valid;
  logic                  out_ready = 1'b1;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [ACT_WIDTH-1:0]  buf_rd_data = '0;
  logic [ACT_WIDTH-1:0]  out_acts;
`ifdef ACT_DISP_PERF_EN
  logic [15:0]           stall_cycles, starve_cycles;
`endif

  act_stream_dispatcher #(
    .ADDR_WIDTH(ADDR_WIDTH), .ACT_WIDTH(ACT_WIDTH), .CNT_WIDTH(CNT_WIDTH),
    .RD_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .addr_stride(addr_stride), .num_tiles(num_tiles), .busy(busy), .done(done),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_acts(out_acts)
`ifdef ACT_DISP_PERF_EN
    , .stall_cycles(stall_cycles), .starve_cycles(starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  // Tile contents derived from the address so that order and identity are visible
  function automatic logic [ACT_WIDTH-1:0] mk(input logic [7:0] a);
    logic [ACT_WIDTH-1:0] v;
    for (int k = 0; k < ACT_WIDTH / 32; k++) v[k*32 +: 32] = {16'hC0DE, a, 8'(k)};
    return v;
  endfunction

  // Activation buffer model with one cycle of read latency
  always @(posedge clk) buf_rd_data <= buf_rd_en ? mk(buf_rd_addr) : '0;

  // Transaction log
  int                   rd_cyc[$];
  logic [7:0]           rd_adr[$];
  int                   bt_cyc[$];
  logic [ACT_WIDTH-1:0] bt_dat[$];
  int                   dn_cyc[$];

  always @(negedge clk) begin
    if (buf_rd_en) begin rd_cyc.push_back(cyc); rd_adr.push_back(buf_rd_addr); end
    if (out_valid && out_ready) begin bt_cyc.push_back(cyc); bt_dat.push_back(out_acts); end
    if (done) dn_cyc.push_back(cyc);
  end

  task automatic clear_log();
    rd_cyc.delete(); rd_adr.delete(); bt_cyc.delete(); bt_dat.delete(); dn_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // Pulses start for one cycle; t is the cycle in which start is high
  task automatic go(input logic [7:0] b, input logic [7:0] s, input logic [7:0] n, output int t);
    step();
    start = 1'b1; base_addr = b; addr_stride = s; num_tiles = n;
    t = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int ndone);
    for (int k = 0; k < 300 && dn_cyc.size() < ndone; k++) sample();
    sample(); sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    sample();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vecs++; if (buf_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en got %b want 0", buf_rd_en); end
    vecs++; if (buf_rd_addr !== 8'h00) begin errs++; $display("FAIL reset_rd_addr got %h want 00", buf_rd_addr); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (out_acts !== '0) begin errs++; $display("FAIL reset_out_acts got %h want 0", out_acts[63:0]); end
  endtask

  task automatic test_basic();
    int t;
    logic [7:0] a;
    int c;
    logic [ACT_WIDTH-1:0] d;
    clear_log(); out_ready = 1'b1;
    go(8'h10, 8'h01, 8'd4, t);
    sample();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_T+1 got %b want 1", busy); end
    wait_done(1);
    vecs++; if (rd_adr.size() != 4) begin errs++; $display("FAIL basic_nreads got %0d want 4", rd_adr.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < rd_adr.size()) ? rd_adr[i] : 8'hxx;
      c = (i < rd_cyc.size()) ? rd_cyc[i] : -1;
      vecs++; if (a !== 8'(8'h10 + i)) begin errs++; $display("FAIL basic_rd_addr[%0d] got %h want %h", i, a, 8'(8'h10 + i)); end
      vecs++; if (c != t + 1 + i) begin errs++; $display("FAIL basic_rd_cycle[%0d] got %0d want %0d", i, c, t + 1 + i); end
    end
    vecs++; if (bt_dat.size() != 4) begin errs++; $display("FAIL basic_nbeats got %0d want 4", bt_dat.size()); end
    for (int i = 0; i < 4; i++) begin
      d = (i < bt_dat.size()) ? bt_dat[i] : 'x;
      c = (i < bt_cyc.size()) ? bt_cyc[i] : -1;
      vecs++; if (d !== mk(8'(8'h10 + i))) begin errs++; $display("FAIL basic_beat_data[%0d] got %h want %h", i, d[63:0], mk(8'(8'h10 + i)) & 64'hFFFF_FFFF_FFFF_FFFF); end
      vecs++; if (c != t + 3 + i) begin errs++; $display("FAIL basic_beat_cycle[%0d] got %0d want %0d", i, c, t + 3 + i); end
    end
    c = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
    vecs++; if (c != t + 7 || dn_cyc.size() != 1) begin errs++; $display("FAIL basic_done_cycle got %0d (n=%0d) want %0d (n=1)", c, dn_cyc.size(), t + 7); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    int t;
    logic [7:0] a;
    logic [7:0] exp_a [4];
    logic [ACT_WIDTH-1:0] d;
    exp_a = '{8'hFC, 8'hFE, 8'h00, 8'h02};
    clear_log(); out_ready = 1'b1;
    go(8'hFC, 8'h02, 8'd4, t);
    wait_done(1);
    vecs++; if (rd_adr.size() != 4) begin errs++; $display("FAIL wrap_nreads got %0d want 4", rd_adr.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < rd_adr.size()) ? rd_adr[i] : 8'hxx;
      d = (i < bt_dat.size()) ? bt_dat[i] : 'x;
      vecs++; if (a !== exp_a[i]) begin errs++; $display("FAIL wrap_rd_addr[%0d] got %h want %h", i, a, exp_a[i]); end
      vecs++; if (d !== mk(exp_a[i])) begin errs++; $display("FAIL wrap_beat_data[%0d] got %h", i, d[63:0]); end
    end
  endtask

  task automatic test_stall();
    int t;
    logic [ACT_WIDTH-1:0] hold;
    logic [ACT_WIDTH-1:0] d;
    int outst;
    clear_log(); out_ready = 1'b1;
    go(8'h20, 8'h01, 8'd8, t);
    step(); step(); step();
    out_ready = 1'b0;
    hold = out_acts;
    vecs++; if (hold !== mk(8'h21)) begin errs++; $display("FAIL stall_head got %h want tile 21", hold[63:0]); end
    for (int k = 0; k < 10; k++) begin
      sample();
      outst = rd_adr.size() - bt_dat.size();
      vecs++; if (out_acts !== hold) begin errs++; $display("FAIL stall_stable[%0d] got %h want %h", k, out_acts[63:0], hold[63:0]); end
      vecs++; if (outst > 4) begin errs++; $display("FAIL stall_outstanding[%0d] got %0d want <=4", k, outst); end
    end
    vecs++; if (buf_rd_en !== 1'b0) begin errs++; $display("FAIL stall_rd_en_off got %b want 0", buf_rd_en); end
    vecs++; if (outst != 4) begin errs++; $display("FAIL stall_filled got %0d want 4", outst); end
    step();
    out_ready = 1'b1;
    wait_done(1);
    vecs++; if (rd_adr.size() != 8) begin errs++; $display("FAIL stall_nreads got %0d want 8", rd_adr.size()); end
    vecs++; if (bt_dat.size() != 8) begin errs++; $display("FAIL stall_nbeats got %0d want 8", bt_dat.size()); end
    for (int i = 0; i < 8; i++) begin
      d = (i < bt_dat.size()) ? bt_dat[i] : 'x;
      vecs++; if (d !== mk(8'(8'h20 + i))) begin errs++; $display("FAIL stall_beat_data[%0d] got %h", i, d[63:0]); end
    end
    vecs++; if (dn_cyc.size() != 1) begin errs++; $display("FAIL stall_ndone got %0d want 1", dn_cyc.size()); end
  endtask

  task automatic test_zero();
    int t;
    int c;
    clear_log(); out_ready = 1'b1;
    go(8'h33, 8'h01, 8'd0, t);
    sample();
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL zero_done_T+1 got %b want 1", done); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy_T+1 got %b want 0", busy); end
    sample();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL zero_done_T+2 got %b want 0", done); end
    repeat (4) sample();
    vecs++; if (rd_adr.size() != 0) begin errs++; $display("FAIL zero_reads got %0d want 0", rd_adr.size()); end
    c = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
    vecs++; if (dn_cyc.size() != 1 || c != t + 1) begin errs++; $display("FAIL zero_done_cycle got %0d (n=%0d) want %0d", c, dn_cyc.size(), t + 1); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy_after got %b want 0", busy); end
  endtask

  task automatic test_reset_midjob();
    int t;
    logic [ACT_WIDTH-1:0] d;
    clear_log(); out_ready = 1'b1;
    go(8'h40, 8'h01, 8'd6, t);
    step();
    rst_n = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || buf_rd_en !== 1'b0)
      begin errs++; $display("FAIL rstmid_ctrl got busy=%b done=%b rd_en=%b want 0", busy, done, buf_rd_en); end
    vecs++; if (buf_rd_addr !== 8'h00) begin errs++; $display("FAIL rstmid_rd_addr got %h want 00", buf_rd_addr); end
    vecs++; if (out_valid !== 1'b0 || out_acts !== '0)
      begin errs++; $display("FAIL rstmid_out got valid=%b acts=%h want 0", out_valid, out_acts[63:0]); end
    repeat (2) step();
    rst_n = 1'b1;
    clear_log();
    go(8'h60, 8'h01, 8'd3, t);
    wait_done(1);
    vecs++; if (rd_adr.size() != 3) begin errs++; $display("FAIL rstmid_nreads got %0d want 3", rd_adr.size()); end
    vecs++; if (bt_dat.size() != 3) begin errs++; $display("FAIL rstmid_nbeats got %0d want 3", bt_dat.size()); end
    for (int i = 0; i < 3; i++) begin
      d = (i < bt_dat.size()) ? bt_dat[i] : 'x;
      vecs++; if (d !== mk(8'(8'h60 + i))) begin errs++; $display("FAIL rstmid_beat_data[%0d] got %h", i, d[63:0]); end
    end
    vecs++; if (dn_cyc.size() != 1) begin errs++; $display("FAIL rstmid_ndone got %0d want 1", dn_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int t;
    logic [7:0] a;
    logic [ACT_WIDTH-1:0] d;
    int c0, c1;
    logic [7:0] exp_a [3];
    exp_a = '{8'h80, 8'h84, 8'hA0};
    clear_log(); out_ready = 1'b1;
    go(8'h80, 8'h04, 8'd2, t);
    step();
    start = 1'b1; base_addr = 8'h99; addr_stride = 8'h01; num_tiles = 8'd5;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; base_addr = 8'hA0; addr_stride = 8'h01; num_tiles = 8'd1;
    sample();
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL b2b_done_at_restart got %b want 1", done); end
    step();
    start = 1'b0;
    wait_done(2);
    vecs++; if (rd_adr.size() != 3) begin errs++; $display("FAIL b2b_nreads got %0d want 3", rd_adr.size()); end
    for (int i = 0; i < 3; i++) begin
      a = (i < rd_adr.size()) ? rd_adr[i] : 8'hxx;
      d = (i < bt_dat.size()) ? bt_dat[i] : 'x;
      vecs++; if (a !== exp_a[i]) begin errs++; $display("FAIL b2b_rd_addr[%0d] got %h want %h", i, a, exp_a[i]); end
      vecs++; if (d !== mk(exp_a[i])) begin errs++; $display("FAIL b2b_beat_data[%0d] got %h", i, d[63:0]); end
    end
    c0 = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
    c1 = (dn_cyc.size() > 1) ? dn_cyc[1] : -1;
    vecs++; if (c0 != t + 5 || c1 != t + 9)
      begin errs++; $display("FAIL b2b_done_cycles got %0d,%0d want %0d,%0d", c0, c1, t + 5, t + 9); end
  endtask

`ifdef ACT_DISP_PERF_EN
  task automatic test_perf();
    int t;
    int m_stall, m_starve;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    m_stall = 0; m_starve = 0;
    clear_log(); out_ready = 1'b1;
    go(8'h50, 8'h01, 8'd8, t);
    for (int k = 0; k < 300; k++) begin
      out_ready = pat[k % 4];
      sample();
      if (out_valid && !out_ready) m_stall++;
      if (busy && !out_valid && out_ready) m_starve++;
      if (done) break;
      step();
    end
    out_ready = 1'b1;
    sample(); sample();
    vecs++; if (bt_dat.size() != 8) begin errs++; $display("FAIL perf_nbeats got %0d want 8", bt_dat.size()); end
    vecs++; if (stall_cycles != 16'(m_stall)) begin errs++; $display("FAIL perf_stall got %0d want %0d", stall_cycles, m_stall); end
    vecs++; if (starve_cycles != 16'(m_starve)) begin errs++; $display("FAIL perf_starve got %0d want %0d", starve_cycles, m_starve); end
    go(8'h10, 8'h01, 8'd2, t);
    sample();
    vecs++; if (stall_cycles !== 16'd0 || starve_cycles !== 16'd0)
      begin errs++; $display("FAIL perf_clear got %0d,%0d want 0,0", stall_cycles, starve_cycles); end
    wait_done(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero();
    test_reset_midjob();
    test_back_to_back();
`ifdef ACT_DISP_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/act_stream_dispatcher.md
Name: act_stream_dispatcher

Overview:
- Parametrised successor to the single-outstanding activation dispatcher.
- Streams `num_tiles` activation tiles from the on-chip activation buffer to the PE array.
- Addresses are `base_addr + i*addr_stride`. Reads are pipelined with a configurable buffer read latency, and a credit-checked output FIFO sustains one tile per cycle.
- Sits between the layer controller (start/done) and the PE array (valid/ready).

Parameters:
- ADDR_WIDTH, 8, buffer address width.
- ACT_WIDTH, 1024, activation bus width (16 groups x 64b).
- CNT_WIDTH, 8, width of tile count and the internal counters.
- RD_LATENCY, 1, cycles from `buf_rd_en` to valid `buf_rd_data` (1..4).
- FIFO_DEPTH, 4, output FIFO entries (power of 2; must be >= RD_LATENCY+2).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, job request; accepted only when busy=0.
- base_addr, input, ADDR_WIDTH, first tile address; sampled at accept.
- addr_stride, input, ADDR_WIDTH, address increment per tile; sampled at accept.
- num_tiles, input, CNT_WIDTH, tiles in the job; sampled at accept; 0 is legal.
- busy, output, 1, job in progress.
- done, output, 1, one-cycle pulse at job completion.
- buf_rd_en, output, 1, buffer read strobe.
- buf_rd_addr, output, ADDR_WIDTH, buffer read address.
- buf_rd_data, input, ACT_WIDTH, read data, valid RD_LATENCY cycles after buf_rd_en.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, PE array accepts.
- out_acts, output, ACT_WIDTH, FIFO head data.

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE. Reset mid-job discards in-flight reads and FIFO contents; no done pulse.
- All outputs are registered except `out_valid`/`out_acts`, which are driven directly from FIFO state/head.
- State IDLE:
  - `start` with num_tiles>0 latches base/stride/count; go to RUN, busy=1 next cycle.
  - `start` with num_tiles=0 pulses done the next cycle; busy stays 0; no reads.
- State RUN, issue logic:
  - Each cycle, buf_rd_en=1 iff issued<num_tiles and (fifo_count + inflight) < FIFO_DEPTH. A pop in the same cycle is not credited.
  - buf_rd_addr = base_addr + issued*addr_stride, wrapping modulo 2^ADDR_WIDTH.
- State RUN, capture:
  - A RD_LATENCY-deep valid shift register tracks in-flight reads.
  - `buf_rd_data` is written to the FIFO on the edge where the matching valid bit exits.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Output:
  - out_valid = FIFO non-empty; out_acts = head entry.
  - Handshake is out_valid && out_ready. out_acts is held stable while out_valid && !out_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Latency, RD_LATENCY=1: start accepted in cycle T, buf_rd_en in T+1, out_valid in T+3.
  - Sustained throughput is 1 tile/cycle when out_ready is held high.
- Completion:
  - When the final tile handshakes, go to IDLE; busy=0 and done=1 on the next cycle.
  - done is high for exactly one cycle.
- `start` while busy is ignored; latched job parameters are unaffected.
- A new `start` may be accepted in the cycle done is high.
- Counter widths: issued/popped are CNT_WIDTH; num_tiles = 2^CNT_WIDTH-1 is the maximum job size.

Optional Feature:
- Macro: ACT_DISP_PERF_EN.
- When defined, two extra ports are added:
  - stall_cycles, output, 16: counts cycles with out_valid && !out_ready.
  - starve_cycles, output, 16: counts cycles with busy && !out_valid && out_ready.
- Both counters clear on job accept, saturate at 0xFFFF, and hold after done.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- base=0x10, stride=1, num_tiles=4, RD_LATENCY=1, out_ready=1:
  - reads 0x10..0x13 on consecutive cycles;
  - 4 beats on consecutive cycles, data in address order;
  - done one cycle after the 4th beat.
- base=0xFC, stride=2, num_tiles=4:
  - read addresses 0xFC, 0xFE, 0x00, 0x02 (wrap).
- out_ready=0 for 10 cycles mid-job, FIFO_DEPTH=4:
  - at most 4 reads outstanding+buffered; buf_rd_en then deasserts;
  - out_acts stable during the stall; no tile lost or duplicated after release.
- num_tiles=0:
  - done pulses the cycle after start; buf_rd_en never asserts; busy stays 0.
- rst_n low while 2 reads are in flight:
  - all outputs 0 immediately;
  - after release, a new start for 3 tiles produces only the 3 new tiles.
- ACT_DISP_PERF_EN, out_ready toggled 1,0,0,1 repeatedly over an 8-tile job:
  - stall_cycles equals the count of valid&&!ready cycles;
  - both counters reset to 0 on the next start.
